// File: rtl/data_mem_responder.sv
// Word-organised data memory on the responder side of the core's data port.
// It clears its array after every reset, then serves masked writes and reads with a one-cycle read latency.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] dm_addr_in,
    input  logic [31:0] dm_wr_data_in,
    input  logic [31:0] dm_wr_mask_in,
    input  logic        dm_wr_req_in,
    output logic [31:0] dm_rd_data_o,
    output logic        mem_ready_o,
    output logic        addr_err_o
);

    localparam int unsigned     IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0]     SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [IDX_W-1:0]  clr_cnt_r;
    logic [31:0]       mem_r [DEPTH_WORDS];
    logic [31:0]       rd_data_r;
    logic              ready_r;
    logic              err_r;

    logic [31:0]       off_s;
    logic              in_range_s;
    logic [IDX_W-1:0]  idx_s;
    logic [31:0]       cur_word_s;
    logic [31:0]       merged_s;
    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_widx_s;
    logic [31:0]       mem_wdata_s;
    logic [31:0]       rd_next_s;
    logic              err_set_s;

    // Addresses below ADDR_BASE wrap to a huge offset and fall out of range.
    assign off_s      = dm_addr_in - ADDR_BASE;
    assign in_range_s = (off_s < SPAN_BYTES);
    assign idx_s      = off_s[IDX_W+1:2];
    assign cur_word_s = mem_r[idx_s];
    assign merged_s   = (cur_word_s & ~dm_wr_mask_in) | (dm_wr_data_in & dm_wr_mask_in);

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_r <= INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state, array write port selection and next read data (write-first).
    always_comb begin
        state_s     = state_r;
        mem_we_s    = 1'b0;
        mem_widx_s  = idx_s;
        mem_wdata_s = merged_s;
        rd_next_s   = 32'h0000_0000;
        err_set_s   = 1'b0;
        case (state_r)
            INIT: begin
                mem_we_s    = 1'b1;
                mem_widx_s  = clr_cnt_r;
                mem_wdata_s = 32'h0000_0000;
                if (clr_cnt_r == LAST_IDX) begin
                    state_s = RUN;
                end else begin
                    state_s = INIT;
                end
            end
            RUN: begin
                if (in_range_s) begin
                    mem_we_s  = dm_wr_req_in;
                    rd_next_s = dm_wr_req_in ? merged_s : cur_word_s;
                end else begin
                    err_set_s = dm_wr_req_in;
                    rd_next_s = 32'h0000_0000;
                end
            end
            default: begin
                state_s = INIT;
            end
        endcase
    end

    // Array write port; contents change only through the sweep or RUN writes.
    always_ff @(posedge clk_in) begin
        if (rst_in && mem_we_s) begin
            mem_r[mem_widx_s] <= mem_wdata_s;
        end
    end

    // Clear counter and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            clr_cnt_r <= {IDX_W{1'b0}};
            rd_data_r <= 32'h0000_0000;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            if (state_r == INIT) begin
                clr_cnt_r <= clr_cnt_r + IDX_W'(1);
            end
            rd_data_r <= rd_next_s;
            ready_r   <= (state_s == RUN);
            err_r     <= err_r | err_set_s;
        end
    end

    assign dm_rd_data_o = rd_data_r;
    assign mem_ready_o  = ready_r;
    assign addr_err_o   = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random traffic
// checked against an array-based reference model of the memory's rules.
module tb_data_mem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] wmask = 32'h0;
    logic        wreq = 1'b0;
    logic [31:0] rd_data;
    logic        ready;
    logic        err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] model_mem [DEPTH];
    int          sweep_left = DEPTH;
    logic [31:0] exp_rd = 32'h0;
    logic        exp_ready = 1'b0;
    logic        exp_err = 1'b0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE)) dut (
        .clk_in(clk), .rst_in(rst), .dm_addr_in(addr), .dm_wr_data_in(wdata),
        .dm_wr_mask_in(wmask), .dm_wr_req_in(wreq), .dm_rd_data_o(rd_data),
        .mem_ready_o(ready), .addr_err_o(err)
    );

    // Apply one clock edge of the memory's rules to the model using the current inputs.
    task automatic model_edge();
        logic [31:0] off;
        int          i;
        if (!rst) begin
            sweep_left = DEPTH;
            exp_rd = 32'h0; exp_ready = 1'b0; exp_err = 1'b0;
        end else if (sweep_left > 0) begin
            model_mem[DEPTH - sweep_left] = 32'h0;
            sweep_left = sweep_left - 1;
            exp_rd = 32'h0;
            exp_ready = (sweep_left == 0);
        end else begin
            off = addr - BASE;
            if (off < 32'(DEPTH * 4)) begin
                i = int'(off >> 2);
                if (wreq) model_mem[i] = (model_mem[i] & ~wmask) | (wdata & wmask);
                exp_rd = model_mem[i];
            end else begin
                exp_rd = 32'h0;
                if (wreq) exp_err = 1'b1;
            end
            exp_ready = 1'b1;
        end
    endtask

    task automatic drive_cycle(input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] m, input logic r);
        addr = a; wdata = d; wmask = m; wreq = r;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_cycle(32'h0, 32'h0, 32'h0, 1'b0);
        drive_cycle(32'h0, 32'h0, 32'h0, 1'b0);
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd actual=%h required=%h", rd_data, 32'h0); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready actual=%b required=0", ready); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err actual=%b required=0", err); end
        rst = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            drive_cycle(32'h0, 32'h0, 32'h0, 1'b0);
            total++; if (ready !== exp_ready) begin bad++; $display("FAIL sweep_ready edge=%0d actual=%b required=%b", k, ready, exp_ready); end
        end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_after_16 actual=%b required=1", ready); end
        for (int k = 0; k < DEPTH; k++) begin
            drive_cycle(BASE + 32'(k * 4), 32'h0, 32'h0, 1'b0);
            total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL clear_word%0d actual=%h required=%h", k, rd_data, 32'h0); end
        end
    endtask

    task automatic test_masked_write();
        drive_cycle(BASE + 32'h8, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1);
        total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL mw_full actual=%h required=%h", rd_data, exp_rd); end
        drive_cycle(BASE + 32'h8, 32'h0000_1234, 32'h0000_FFFF, 1'b1);
        total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL mw_half actual=%h required=%h", rd_data, exp_rd); end
        drive_cycle(BASE + 32'h8, 32'hFFFF_FFFF, 32'h0, 1'b0);
        total++; if (rd_data !== 32'hDEAD_1234) begin bad++; $display("FAIL mw_read8 actual=%h required=%h", rd_data, 32'hDEAD_1234); end
        drive_cycle(BASE + 32'hB, 32'h0, 32'h0, 1'b0);
        total++; if (rd_data !== 32'hDEAD_1234) begin bad++; $display("FAIL mw_readB actual=%h required=%h", rd_data, 32'hDEAD_1234); end
        drive_cycle(BASE + 32'h8, 32'h5555_5555, 32'h0, 1'b1);
        total++; if (rd_data !== 32'hDEAD_1234) begin bad++; $display("FAIL mw_mask0 actual=%h required=%h", rd_data, 32'hDEAD_1234); end
    endtask

    task automatic test_write_first();
        drive_cycle(BASE + 32'h4, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b1);
        total++; if (rd_data !== 32'hA5A5_A5A5) begin bad++; $display("FAIL write_first actual=%h required=%h", rd_data, 32'hA5A5_A5A5); end
    endtask

    task automatic test_out_of_range();
        drive_cycle(BASE + 32'h40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_err_set actual=%b required=1", err); end
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL oor_rd actual=%h required=%h", rd_data, 32'h0); end
        drive_cycle(BASE + 32'h40, 32'h0, 32'h0, 1'b0);
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL oor_read actual=%h required=%h", rd_data, 32'h0); end
        drive_cycle(32'h0000_0FFC, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_err_sticky actual=%b required=1", err); end
        for (int k = 0; k < DEPTH; k++) begin
            drive_cycle(BASE + 32'(k * 4), 32'h0, 32'h0, 1'b0);
            total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL oor_word%0d actual=%h required=%h", k, rd_data, exp_rd); end
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL oor_err_persist actual=%b required=1", err); end
    endtask

    task automatic test_init_ignores();
        rst = 1'b0;
        drive_cycle(32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_cycle((k % 2 == 0) ? BASE : BASE + 32'h40, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
            total++; if (err !== 1'b0) begin bad++; $display("FAIL init_err cyc=%0d actual=%b required=0", k, err); end
            total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL init_rd cyc=%0d actual=%h required=%h", k, rd_data, 32'h0); end
        end
        for (int k = 10; k < DEPTH; k++) begin
            drive_cycle(32'h0, 32'h0, 32'h0, 1'b0);
            total++; if (ready !== exp_ready) begin bad++; $display("FAIL init_ready edge=%0d actual=%b required=%b", k, ready, exp_ready); end
        end
        drive_cycle(BASE, 32'h0, 32'h0, 1'b0);
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL init_word0 actual=%h required=%h", rd_data, 32'h0); end
    endtask

    task automatic test_reset_mid();
        drive_cycle(BASE, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        total++; if (rd_data !== 32'h1) begin bad++; $display("FAIL mid_write actual=%h required=%h", rd_data, 32'h1); end
        drive_cycle(BASE - 32'h4, 32'h1, 32'hFFFF_FFFF, 1'b1);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL mid_err_set actual=%b required=1", err); end
        rst = 1'b0;
        drive_cycle(32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_ready actual=%b required=0", ready); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err_clr actual=%b required=0", err); end
        for (int k = 0; k < DEPTH; k++) begin
            drive_cycle(32'h0, 32'h0, 32'h0, 1'b0);
            total++; if (ready !== exp_ready) begin bad++; $display("FAIL mid_sweep edge=%0d actual=%b required=%b", k, ready, exp_ready); end
        end
        drive_cycle(BASE, 32'h0, 32'h0, 1'b0);
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL mid_word0 actual=%h required=%h", rd_data, 32'h0); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, m;
        logic        r;
        for (int k = 0; k < 400; k++) begin
            a = BASE + 32'($urandom_range(0, 87)) - 32'd8;
            d = $urandom;
            case ($urandom_range(0, 3))
                0:       m = 32'h0;
                1:       m = 32'hFFFF_FFFF;
                default: m = $urandom;
            endcase
            r = ($urandom_range(0, 2) != 0);
            drive_cycle(a, d, m, r);
            total++; if (rd_data !== exp_rd) begin bad++; $display("FAIL rand_rd cyc=%0d addr=%h actual=%h required=%h", k, a, rd_data, exp_rd); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL rand_err cyc=%0d actual=%b required=%b", k, err, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_masked_write();
        test_write_first();
        test_out_of_range();
        test_init_ignores();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
